// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst (read-only) and data (read/write) SRAM-like ports onto a single
// AXI master with at most one read and one write in flight.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  input  logic [1:0]  inst_sram_size,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R, R_DONE} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_B, W_DONE} w_state_e;

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic        r_src_data_q, r_src_data_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [1:0]  ar_size_q, ar_size_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [1:0]  aw_size_q, aw_size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic r_free, data_rd_inflight, data_rd_acc, data_wr_acc, inst_acc;

  // R_DONE is free too: the returning read retires this cycle, so a new one may start.
  assign r_free           = (r_state_q == R_IDLE) || (r_state_q == R_DONE);
  assign data_rd_inflight = r_src_data_q && ((r_state_q == R_AR) || (r_state_q == R_R));
  assign data_rd_acc      = resetn && data_sram_req && !data_sram_wr && r_free && (w_state_q == W_IDLE);
  assign data_wr_acc      = resetn && data_sram_req && data_sram_wr && (w_state_q == W_IDLE) && !data_rd_inflight;
  assign inst_acc         = resetn && inst_sram_req && r_free && !data_rd_acc;

  assign inst_sram_addr_ok = inst_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_sram_data_ok = (r_state_q == R_DONE) && !r_src_data_q;
  assign data_sram_data_ok = ((r_state_q == R_DONE) && r_src_data_q) || (w_state_q == W_DONE);
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_rdata   = data_rdata_q;

  assign arid    = r_src_data_q ? DATA_ID : INST_ID;
  assign araddr  = ar_addr_q;
  assign arsize  = {1'b0, ar_size_q};
  assign arvalid = (r_state_q == R_AR);
  assign rready  = (r_state_q == R_R);
  assign awaddr  = aw_addr_q;
  assign awsize  = {1'b0, aw_size_q};
  assign awvalid = (w_state_q == W_SEND) && !aw_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wvalid  = (w_state_q == W_SEND) && !w_done_q;
  assign bready  = (w_state_q == W_B);

  always_comb begin
    r_state_d    = r_state_q;
    r_src_data_d = r_src_data_q;
    ar_addr_d    = ar_addr_q;
    ar_size_d    = ar_size_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    case (r_state_q)
      R_IDLE, R_DONE: begin
        r_state_d = R_IDLE;
        if (data_rd_acc || inst_acc) begin
          r_state_d    = R_AR;
          r_src_data_d = data_rd_acc;
          ar_addr_d    = data_rd_acc ? data_sram_addr : inst_sram_addr;
          ar_size_d    = data_rd_acc ? data_sram_size : inst_sram_size;
        end
      end
      R_AR: if (arready) r_state_d = R_R;
      R_R: begin
        // Only one read is outstanding, so the latched source routes the return.
        if (rvalid) begin
          r_state_d = R_DONE;
          if (r_src_data_q) data_rdata_d = rdata;
          else              inst_rdata_d = rdata;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    aw_size_d = aw_size_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (data_wr_acc) begin
          w_state_d = W_SEND;
          aw_addr_d = data_sram_addr;
          aw_size_d = data_sram_size;
          wstrb_d   = data_sram_wstrb;
          wdata_d   = data_sram_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_SEND: begin
        aw_done_d = aw_done_q || awready;
        w_done_d  = w_done_q || wready;
        if (aw_done_d && w_done_d) w_state_d = W_B;
      end
      W_B:     if (bvalid) w_state_d = W_DONE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q    <= R_IDLE;
      w_state_q    <= W_IDLE;
      r_src_data_q <= 1'b0;
      ar_addr_q    <= '0;
      ar_size_q    <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      aw_addr_q    <= '0;
      aw_size_q    <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      w_state_q    <= w_state_d;
      r_src_data_q <= r_src_data_d;
      ar_addr_q    <= ar_addr_d;
      ar_size_q    <= ar_size_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      aw_addr_q    <= aw_addr_d;
      aw_size_q    <= aw_size_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end
endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Converts the core's two SRAM-like request/addr_ok/data_ok ports into a single AXI master.
- The inst port is read-only; the data port is read/write.
- Sits directly downstream of the pipeline core and is instantiated beside it in the CPU top.
- Allows at most one read and one write in flight, with conservative ordering so no data hazard ever reaches the AXI side.

Parameters:
- INST_ID, 4'd0, arid driven for inst-port reads.
- DATA_ID, 4'd1, arid driven for data-port reads; awid is tied to this value internally.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_sram_req/inst_sram_addr/inst_sram_size  in  1/32/2  inst read request; held until addr_ok.
- inst_sram_addr_ok/inst_sram_data_ok  out  1/1  inst accept / return strobes.
- inst_sram_rdata  out  32  inst read data, valid with data_ok.
- data_sram_req/data_sram_wr/data_sram_size  in  1/1/2  data request, write flag, size (0=byte, 1=half, 2=word).
- data_sram_addr/data_sram_wstrb/data_sram_wdata  in  32/4/32  data address, byte strobes, write data.
- data_sram_addr_ok/data_sram_data_ok  out  1/1  data accept / completion strobes.
- data_sram_rdata  out  32  data read data, valid with data_ok.
- arid/araddr/arsize/arvalid  out  4/32/3/1  AXI read address channel.
- arready  in  1
- rdata/rvalid  in  32/1
- rready  out  1
- awaddr/awsize/awvalid  out  32/3/1  AXI write address channel.
- awready  in  1
- wdata/wstrb/wvalid  out  32/4/1  AXI write data channel.
- wready  in  1
- bvalid  in  1
- bready  out  1

Behaviour:
- AXI constants: single-beat bursts, len=0, INCR; arsize/awsize = {1'b0, size}; address and strobes pass through unchanged.
- Read FSM states: R_IDLE, R_AR, R_R, R_DONE.
  - data_sram_addr_ok (read) = data_sram_req & ~wr & R_IDLE & W_IDLE.
  - inst_sram_addr_ok = inst_sram_req & R_IDLE & ~data_sram_addr_ok_read. Data reads have priority; inst proceeds while a data read is blocked by a write.
  - On accept at cycle T: latch addr, size, and the source (inst/data); go to R_AR.
  - arvalid=1 from T+1 until arready; then R_R with rready=1.
  - On rvalid: capture rdata into the owner's rdata register; go to R_DONE.
  - In R_DONE: pulse the owner's data_ok for exactly 1 cycle; return to R_IDLE. The next read can be accepted in that same cycle.
  - Return routing uses the latched source only; rid is ignored because only one read is outstanding.
- Write FSM states: W_IDLE, W_SEND, W_B, W_DONE.
  - data_sram_addr_ok (write) = data_sram_req & wr & W_IDLE & ~(read in flight owned by data).
  - On accept: latch addr, size, wstrb, wdata; go to W_SEND.
  - awvalid and wvalid both assert the next cycle; each deasserts independently on its own handshake.
  - When both handshakes are complete: W_B with bready=1.
  - On bvalid: W_DONE; pulse data_sram_data_ok for 1 cycle; return to W_IDLE.
- Ordering:
  - A data read is never accepted while a write is outstanding.
  - A write is never accepted while a data read is outstanding.
  - Consequence: data-port read and write completions never coincide. Inst and data data_ok may pulse in the same cycle.
- addr_ok is combinational from req and state. data_ok is registered. rdata holds its value until the next return.
- Reset (async, resetn=0), any cycle: FSMs go to IDLE. All valid/ready/ok outputs are 0; rdata registers are 0; latched request registers are 0. In-flight AXI transactions are abandoned.

Test Plan:
- Inst read only, addr 0x1C000000, arready after 2 cycles, rvalid after 3 more with rdata 0x02800C0C -> arid=0, araddr=0x1C000000, arsize=2; inst_sram_data_ok pulses once with rdata 0x02800C0C; data_sram_data_ok stays 0.
- Inst and data read requested in the same cycle (inst 0x1C000004, data 0x00001000) -> data accepted first (arid=1); inst addr_ok only after data_ok; two arvalid transactions in order.
- Byte store, size=0, addr 0x00001003, wstrb 4'b1000, wdata 0xAB000000, awready 3 cycles before wready -> awvalid drops after awready, wvalid stays high until wready; bready=1; single data_sram_data_ok after bvalid.
- Write outstanding (bvalid delayed 10 cycles) plus data read and inst read pending -> data read addr_ok held 0 until write data_ok; inst read is accepted and completes during the wait.
- rvalid and bvalid returned in the same cycle (inst read + data write) -> inst_sram_data_ok and data_sram_data_ok both pulse the following cycle; each has the correct data.
- resetn dropped while in R_R and W_SEND -> outputs 0 immediately; after release, a fresh inst read completes normally with no spurious data_ok.
